// File: rtl/user_obi_addr_demux_if.sv
// OBI demux bus bundle: manager side plus the fanned-out subordinate side.
// The slave modport is the demux's view; master is the surrounding system.
interface user_obi_addr_demux_if #(
  parameter int unsigned NumSbr    = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxTrans  = 4
) ();
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  logic                        mgr_req_i;
  logic                        mgr_gnt_o;
  logic [AddrWidth-1:0]        mgr_addr_i;
  logic                        mgr_we_i;
  logic [DataWidth/8-1:0]      mgr_be_i;
  logic [DataWidth-1:0]        mgr_wdata_i;
  logic                        mgr_rvalid_o;
  logic [DataWidth-1:0]        mgr_rdata_o;
  logic                        mgr_err_o;
  logic [NumSbr-1:0]           sbr_req_o;
  logic [NumSbr-1:0]           sbr_gnt_i;
  logic [AddrWidth-1:0]        sbr_addr_o;
  logic                        sbr_we_o;
  logic [DataWidth/8-1:0]      sbr_be_o;
  logic [DataWidth-1:0]        sbr_wdata_o;
  logic [NumSbr-1:0]           sbr_rvalid_i;
  logic [NumSbr*DataWidth-1:0] sbr_rdata_i;
  logic [NumSbr-1:0]           sbr_err_i;
  logic [CntW-1:0]             outstanding_o;

  modport slave (
    input  mgr_req_i, mgr_addr_i, mgr_we_i, mgr_be_i, mgr_wdata_i,
    output mgr_gnt_o, mgr_rvalid_o, mgr_rdata_o, mgr_err_o,
    output sbr_req_o, sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o,
    input  sbr_gnt_i, sbr_rvalid_i, sbr_rdata_i, sbr_err_i,
    output outstanding_o
  );

  modport master (
    output mgr_req_i, mgr_addr_i, mgr_we_i, mgr_be_i, mgr_wdata_i,
    input  mgr_gnt_o, mgr_rvalid_o, mgr_rdata_o, mgr_err_o,
    input  sbr_req_o, sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o,
    output sbr_gnt_i, sbr_rvalid_i, sbr_rdata_i, sbr_err_i,
    input  outstanding_o
  );
endinterface

// File: rtl/user_obi_addr_demux.sv
// User-domain OBI address demux: rule-table decode, in-order responses,
// built-in error subordinate for unmapped addresses.
module user_obi_addr_demux #(
  parameter int unsigned NumSbr    = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxTrans  = 4,
  parameter logic [NumSbr-1:0][AddrWidth-1:0] SbrStart =
    {32'h2000_1000, 32'h2000_0000},
  parameter logic [NumSbr-1:0][AddrWidth-1:0] SbrEnd =
    {32'h2000_2000, 32'h2000_1000},
  parameter logic [DataWidth-1:0] ErrRdata = 32'hBADC_AB1E
) (
  input logic                   clk_i,
  input logic                   rst_i,
  user_obi_addr_demux_if.slave  bus
);
  localparam int unsigned SelW = $clog2(NumSbr + 1);
  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam logic [SelW-1:0] SelErr = SelW'(NumSbr);

  logic [SelW-1:0]      r_last_sel;
  logic [CntW-1:0]      r_cnt;
  logic                 r_err_rvalid;

  logic [SelW-1:0]      w_sel;
  logic                 w_is_err;
  logic                 w_ok;
  logic                 w_fire;
  logic                 w_gnt;
  logic                 w_sbr_gnt;
  logic [NumSbr-1:0]    w_sbr_req;
  logic                 w_rsp_raw;
  logic                 w_rsp;
  logic [DataWidth-1:0] w_rdata;
  logic                 w_err;
  logic [CntW-1:0]      w_cnt_eff;
  logic [NumSbr-1:0]    w_last_mask;
  logic                 w_spurious;

  // Address decode: lowest matching rule wins, no match -> error target.
  always_comb begin
    w_sel = SelErr;
    for (int i = NumSbr - 1; i >= 0; i--) begin
      if (bus.mgr_addr_i >= SbrStart[i] &&
          bus.mgr_addr_i <  SbrEnd[i]) begin
        w_sel = SelW'(i);
      end
    end
  end

  assign w_is_err = (w_sel == SelErr);

  // Response mux from the target that owns all in-flight transactions.
  always_comb begin
    w_rsp_raw   = 1'b0;
    w_rdata     = '0;
    w_err       = 1'b0;
    w_last_mask = '0;
    if (r_last_sel == SelErr) begin
      w_rsp_raw = r_err_rvalid;
      w_rdata   = ErrRdata;
      w_err     = 1'b1;
    end
    for (int i = 0; i < NumSbr; i++) begin
      if (r_last_sel == SelW'(i)) begin
        w_last_mask[i] = 1'b1;
        w_rsp_raw      = bus.sbr_rvalid_i[i];
        w_rdata        = bus.sbr_rdata_i[i*DataWidth +: DataWidth];
        w_err          = bus.sbr_err_i[i];
      end
    end
  end

  assign w_rsp     = w_rsp_raw & (r_cnt != '0);
  // A response this cycle frees its slot for an admission this cycle.
  assign w_cnt_eff = r_cnt - CntW'(w_rsp);
  assign w_ok      = ((w_cnt_eff == '0) || (w_sel == r_last_sel)) &&
                     (w_cnt_eff < CntW'(MaxTrans));

  // Request routing and grant selection.
  always_comb begin
    w_sbr_req = '0;
    w_sbr_gnt = 1'b0;
    for (int i = 0; i < NumSbr; i++) begin
      if (w_sel == SelW'(i)) begin
        w_sbr_req[i] = bus.mgr_req_i & w_ok;
        w_sbr_gnt    = bus.sbr_gnt_i[i];
      end
    end
  end

  assign w_gnt  = w_ok & (w_is_err ? bus.mgr_req_i : w_sbr_gnt);
  assign w_fire = bus.mgr_req_i & w_gnt;

  assign bus.mgr_gnt_o     = w_gnt;
  assign bus.sbr_req_o     = w_sbr_req;
  assign bus.sbr_addr_o    = bus.mgr_addr_i;
  assign bus.sbr_we_o      = bus.mgr_we_i;
  assign bus.sbr_be_o      = bus.mgr_be_i;
  assign bus.sbr_wdata_o   = bus.mgr_wdata_i;
  assign bus.mgr_rvalid_o  = w_rsp;
  assign bus.mgr_rdata_o   = w_rsp ? w_rdata : '0;
  assign bus.mgr_err_o     = w_rsp & w_err;
  assign bus.outstanding_o = r_cnt;

  // Outstanding count, owning target and error-subordinate response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt        <= '0;
      r_last_sel   <= '0;
      r_err_rvalid <= 1'b0;
    end else begin
      r_err_rvalid <= w_fire & w_is_err;
      if (w_fire) begin
        r_last_sel <= w_sel;
      end
      if (w_fire && !w_rsp) begin
        r_cnt <= r_cnt + CntW'(1);
      end else if (!w_fire && w_rsp) begin
        r_cnt <= r_cnt - CntW'(1);
      end
    end
  end

  assign w_spurious = (|bus.sbr_rvalid_i) &&
                      ((r_cnt == '0) ||
                       (|(bus.sbr_rvalid_i & ~w_last_mask)));

  // Flag responses that arrive with nothing in flight or from a non-owner.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!w_spurious)
        else $warning("demux: unexpected subordinate response ignored");
    end
  end
endmodule
